mac_stream_driver: RTL

Host-side initiator for the `TPU_functional` multiply-accumulate unit. The block accepts a stream of 8-bit operand pairs grouped into vectors over a valid/ready handshake and buffers them in a small FIFO. It drives each pair into the MAC, then issues the `out_HL` read strobe, captures the 17-bit dot-product and error flag, and returns them on a result valid/ready handshake. It clears the MAC before every vector and sits between the host/DMA side and the MAC.

---
 rtl/mac_stream_driver_if.sv | 26 ++
 rtl/mac_stream_driver.sv | 112 +++++++++++
 2 files changed

// File: rtl/mac_stream_driver_if.sv
// Host-side bundle for mac_stream_driver: operand push stream in, result stream out.
// The host drives the master modport; the driver implements the slave modport.
interface mac_stream_driver_if #(
   parameter int LEN_W = 8
);
   logic             op_valid;
   logic             op_ready;
   logic [7:0]       op_a;
   logic [7:0]       op_b;
   logic             op_last;
   logic             res_valid;
   logic             res_ready;
   logic [16:0]      res_data;
   logic             res_error;
   logic [LEN_W-1:0] res_count;

   modport master (
      output op_valid, op_a, op_b, op_last, res_ready,
      input  op_ready, res_valid, res_data, res_error, res_count
   );

   modport slave (
      input  op_valid, op_a, op_b, op_last, res_ready,
      output op_ready, res_valid, res_data, res_error, res_count
   );
endinterface

// File: rtl/mac_stream_driver.sv
// Feeds buffered operand pairs into the TPU_functional MAC one vector at a time,
// then strobes out_HL and returns the captured dot-product and error flag.
module mac_stream_driver #(
   parameter int DEPTH  = 4,
   parameter int LEN_W  = 8,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   mac_stream_driver_if.slave   host,
   output logic                 busy,
   output logic                 mac_reset,
   output logic [7:0]           mac_in1,
   output logic [7:0]           mac_in2,
   output logic                 mac_out_hl,
   input  logic [16:0]          mac_out,
   input  logic                 mac_error
);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   localparam logic [2:0] S_CLEAR  = 3'd0;
   localparam logic [2:0] S_FEED   = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_READ   = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_RESULT = 3'd5;

   logic [2:0]       state;
   logic [16:0]      mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             empty, full, push, pop;
   logic [16:0]      head;
   logic [LEN_W-1:0] count;
   logic             sat;
   logic [WW-1:0]    wait_cnt;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
   assign head  = mem[rd_ptr[AW-1:0]];

   assign host.op_ready  = reset && !full;
   assign push           = host.op_valid && host.op_ready;
   assign pop            = (state == S_FEED) && !empty;

   assign host.res_valid = (state == S_RESULT);
   assign mac_reset      = (state == S_CLEAR);
   assign mac_out_hl     = (state == S_READ);
   assign busy           = !((state == S_CLEAR) && empty);

   // NOTE: storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {host.op_a, host.op_b, host.op_last};
   end

   // NOTE: all state updates use <= so every branch sees the pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_CLEAR;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         sat            <= 1'b0;
         wait_cnt       <= '0;
         mac_in1        <= '0;
         mac_in2        <= '0;
         host.res_data  <= '0;
         host.res_error <= 1'b0;
         host.res_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         mac_in1 <= '0;
         mac_in2 <= '0;
         case (state)
            S_CLEAR: begin
               count <= '0;
               sat   <= 1'b0;
               state <= S_FEED;
            end
            S_FEED: begin
               if (!empty) begin
                  mac_in1 <= head[16:9];
                  mac_in2 <= head[8:1];
                  if (count == CNT_MAX) sat   <= 1'b1;
                  else                  count <= count + 1'b1;
                  if (head[0]) state <= S_DRAIN;
               end
            end
            S_DRAIN: state <= S_READ;
            S_READ: begin
               wait_cnt <= WW'(RD_LAT - 1);
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == '0) begin
                  host.res_data  <= mac_out;
                  host.res_error <= mac_error | sat;
                  host.res_count <= count;
                  state          <= S_RESULT;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            S_RESULT: if (host.res_ready) state <= S_CLEAR;
            default:  state <= S_CLEAR;
         endcase
      end
   end
endmodule
